// File: rtl/rtc_xfer_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : rtc_xfer_engine_if
// Purpose  : Core-side handshaked bus of the RTC/save-state shadow engine.
//            The engine is the master: it drives load writes and the register
//            index. The core is the slave: it returns valid/ack/read data.
// Revision : 1.0 - initial release
// ============================================================================
interface rtc_xfer_engine_if #(
  parameter int DATA_W  = 16,
  parameter int CORE_AW = 17
);
  logic               core_valid;
  logic [CORE_AW-1:0] core_addr;
  logic [DATA_W-1:0]  core_wdata;
  logic               core_wr;
  logic               core_ack;
  logic [DATA_W-1:0]  core_rdata;

  modport master (
    input  core_valid,
    input  core_ack,
    input  core_rdata,
    output core_addr,
    output core_wdata,
    output core_wr
  );

  modport slave (
    output core_valid,
    output core_ack,
    output core_rdata,
    input  core_addr,
    input  core_wdata,
    input  core_wr
  );
endinterface
`default_nettype wire

// File: rtl/rtc_xfer_engine.sv
`default_nettype none
// ============================================================================
// Module   : rtc_xfer_engine
// Purpose  : Shadow buffer between the host bridge and the core. Host-written
//            words are replayed into the core over a handshaked write port;
//            a save pass captures live core registers back for readback.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_xfer_engine #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 10,
  parameter int HOST_AW = 5,
  parameter int CORE_AW = 17
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               clear,
  input  logic               host_wr,
  input  logic [HOST_AW-1:0] host_addr,
  input  logic [DATA_W-1:0]  host_wdata,
  input  logic [HOST_AW-1:0] host_rd_addr,
  output logic [DATA_W-1:0]  host_rdata,
  rtc_xfer_engine_if.master  core,
  input  logic               save_req,
  output logic               load_done,
  output logic               save_done,
  output logic               busy
);

  // Index arithmetic is done one bit wider so DEPTH == 2**HOST_AW is legal.
  localparam logic [HOST_AW:0] c_depth = (HOST_AW + 1)'(DEPTH);
  localparam logic [HOST_AW:0] c_one   = (HOST_AW + 1)'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LD_RD   = 3'd1,
    ST_LD_WAIT = 3'd2,
    ST_LD_WR   = 3'd3,
    ST_LD_INC  = 3'd4,
    ST_SV_ADDR = 3'd5,
    ST_SV_CAP  = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  state_t              r_state;
  logic [HOST_AW-1:0]  r_idx;
  logic                r_host_wr_d;
  logic                r_loaded;
  logic [DATA_W-1:0]   r_q;
  logic                r_core_wr;
  logic [DATA_W-1:0]   r_core_wdata;
  logic [CORE_AW-1:0]  r_core_addr;
  logic                r_load_done;
  logic                r_save_done;
  logic [DATA_W-1:0]   r_mem [2**HOST_AW];

  logic                w_host_we;
  logic                w_sv_we;
  logic [HOST_AW:0]    w_idx_next;
  logic                w_idx_last;
  logic [HOST_AW-1:0]  w_rd_addr;

  // Out-of-range host writes never reach the buffer.
  assign w_host_we  = host_wr && ({1'b0, host_addr} < c_depth);
  // A host write owns the write port; the save capture waits a cycle.
  assign w_sv_we    = (r_state == ST_SV_CAP) && !w_host_we && !reset && !clear;
  assign w_idx_next = {1'b0, r_idx} + c_one;
  assign w_idx_last = (w_idx_next >= c_depth);
  // The FSM borrows the read port only in LD_RD; host readback otherwise.
  assign w_rd_addr  = (r_state == ST_LD_RD) ? r_idx : host_rd_addr;

  assign host_rdata      = r_q;
  assign core.core_wr    = r_core_wr;
  assign core.core_wdata = r_core_wdata;
  assign core.core_addr  = r_core_addr;
  assign load_done       = r_load_done;
  assign save_done       = r_save_done;
  assign busy            = (r_state != ST_IDLE) && (r_state != ST_DONE);

  // Buffer write port: contents are deliberately not reset.
  always_ff @(posedge clk_sys) begin
    if (w_host_we) begin
      r_mem[host_addr] <= host_wdata;
    end else if (w_sv_we) begin
      r_mem[r_idx] <= core.core_rdata;
    end
  end

  // Buffer read port, registered, shared by host readback and load reads.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_q <= '0;
    end else begin
      r_q <= r_mem[w_rd_addr];
    end
  end

  // Loaded flag: armed by a rising edge of host_wr, clear wins over the edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_host_wr_d <= 1'b0;
      r_loaded    <= 1'b0;
    end else begin
      r_host_wr_d <= host_wr;
      if (clear) begin
        r_loaded <= 1'b0;
      end else if (host_wr && !r_host_wr_d) begin
        r_loaded <= 1'b1;
      end
    end
  end

  // Transfer FSM with registered core-side outputs.
  always_ff @(posedge clk_sys) begin
    if (reset || clear) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_core_wr    <= 1'b0;
      r_core_wdata <= '0;
      r_core_addr  <= '0;
      r_load_done  <= 1'b0;
      r_save_done  <= 1'b0;
    end else begin
      r_save_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Load has priority; a coincident save request is dropped.
          if (r_loaded && core.core_valid) begin
            r_state <= ST_LD_RD;
          end else if (save_req) begin
            r_core_addr <= CORE_AW'(r_idx);
            r_state     <= ST_SV_ADDR;
          end
        end
        ST_LD_RD: begin
          r_state <= ST_LD_WAIT;
        end
        ST_LD_WAIT: begin
          // Latch q now: the read port returns to the host next cycle.
          r_core_wdata <= r_q;
          r_core_addr  <= CORE_AW'(r_idx);
          r_core_wr    <= 1'b1;
          r_state      <= ST_LD_WR;
        end
        ST_LD_WR: begin
          if (core.core_ack) begin
            r_core_wr <= 1'b0;
            r_state   <= ST_LD_INC;
          end
        end
        ST_LD_INC: begin
          if (!w_idx_last) begin
            r_idx   <= w_idx_next[HOST_AW-1:0];
            r_state <= ST_LD_RD;
          end else begin
            r_idx       <= '0;
            r_load_done <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_SV_ADDR: begin
          r_state <= ST_SV_CAP;
        end
        ST_SV_CAP: begin
          // Stay here while a host write holds the buffer write port.
          if (!w_host_we) begin
            if (!w_idx_last) begin
              r_idx       <= w_idx_next[HOST_AW-1:0];
              r_core_addr <= CORE_AW'(w_idx_next);
              r_state     <= ST_SV_ADDR;
            end else begin
              r_idx       <= '0;
              r_core_addr <= '0;
              r_save_done <= 1'b1;
              r_state     <= r_load_done ? ST_DONE : ST_IDLE;
            end
          end
        end
        ST_DONE: begin
          if (save_req) begin
            r_core_addr <= CORE_AW'(r_idx);
            r_state     <= ST_SV_ADDR;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rtc_xfer_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtc_xfer_engine
// Purpose  : Self-checking bench for rtc_xfer_engine. Expected core writes
//            are queued when a load is triggered and popped on each accepted
//            core_wr; a small core model supplies ack and register data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_xfer_engine;
  localparam int DATA_W  = 16;
  localparam int DEPTH   = 10;
  localparam int HOST_AW = 5;
  localparam int CORE_AW = 17;

  typedef struct packed {
    logic [CORE_AW-1:0] addr;
    logic [DATA_W-1:0]  data;
  } xfer_t;

  logic               clk_sys = 1'b0;
  logic               reset;
  logic               clear;
  logic               host_wr;
  logic [HOST_AW-1:0] host_addr;
  logic [DATA_W-1:0]  host_wdata;
  logic [HOST_AW-1:0] host_rd_addr;
  logic [DATA_W-1:0]  host_rdata;
  logic               save_req;
  logic               load_done;
  logic               save_done;
  logic               busy;

  logic               core_valid_drv;
  int                 ack_hold_word;
  int                 hold_cnt = 0;
  logic [DATA_W-1:0]  core_rdata_q = '0;
  int                 cyc = 0;

  xfer_t              sb_q[$];
  logic [DATA_W-1:0]  exp_mem [DEPTH];
  int                 n_checks = 0;
  int                 n_fail = 0;

  int                 wr_cycles = 0;
  int                 word_wr_cycles = 0;
  int                 ack_count = 0;
  int                 last_ack_cyc = -100;
  bit                 check_spacing = 1'b0;

  rtc_xfer_engine_if #(.DATA_W(DATA_W), .CORE_AW(CORE_AW)) core_bus ();

  rtc_xfer_engine #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .HOST_AW(HOST_AW),
    .CORE_AW(CORE_AW)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .clear       (clear),
    .host_wr     (host_wr),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rd_addr(host_rd_addr),
    .host_rdata  (host_rdata),
    .core        (core_bus),
    .save_req    (save_req),
    .load_done   (load_done),
    .save_done   (save_done),
    .busy        (busy)
  );

  always #5 clk_sys = ~clk_sys;

  // Core model: ack is high except on the held word, which is acked on its
  // fourth core_wr cycle; register reads return 0xA000 | addr one cycle late.
  assign core_bus.core_valid = core_valid_drv;
  assign core_bus.core_rdata = core_rdata_q;
  assign core_bus.core_ack   = (ack_hold_word < 0) ||
                               (int'(core_bus.core_addr) != ack_hold_word) ||
                               (hold_cnt >= 3);

  // Cycle counter and registered core behaviour.
  always @(posedge clk_sys) begin
    cyc          <= cyc + 1;
    core_rdata_q <= 16'hA000 | core_bus.core_addr[DATA_W-1:0];
    if (core_bus.core_wr && !core_bus.core_ack) hold_cnt <= hold_cnt + 1;
    else                                        hold_cnt <= 0;
  end

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic host_write(input int a, input logic [DATA_W-1:0] d);
    host_addr  = HOST_AW'(a);
    host_wdata = d;
    host_wr    = 1'b1;
    tick();
    host_wr    = 1'b0;
    tick();
  endtask

  task automatic host_read(input int a, output logic [DATA_W-1:0] d);
    host_rd_addr = HOST_AW'(a);
    tick();
    d = host_rdata;
  endtask

  task automatic push_all();
    for (int i = 0; i < DEPTH; i++) begin
      xfer_t e;
      e.addr = CORE_AW'(i);
      e.data = exp_mem[i];
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_load_done(input int bound, output int done_cyc);
    int n;
    n = 0;
    while (!load_done && n < bound) begin
      tick();
      n++;
    end
    check_value("load_done_timeout", 32'(load_done), 32'd1);
    done_cyc = cyc;
  endtask

  // Handshake monitor: scoreboard pops, hold stability, word spacing.
  initial begin : monitor
    logic               prev_wr;
    logic               prev_ack;
    logic [CORE_AW-1:0] prev_addr;
    logic [DATA_W-1:0]  prev_data;
    xfer_t              e;
    prev_wr   = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = '0;
    prev_data = '0;
    forever begin
      @(negedge clk_sys);
      if (core_bus.core_wr) begin
        wr_cycles++;
        if (ack_hold_word >= 0 && int'(core_bus.core_addr) == ack_hold_word)
          word_wr_cycles++;
        if (prev_wr && !prev_ack) begin
          check_value("hold_addr", 32'(core_bus.core_addr), 32'(prev_addr));
          check_value("hold_data", 32'(core_bus.core_wdata), 32'(prev_data));
        end
        if (core_bus.core_ack) begin
          if (sb_q.size() == 0) begin
            check_value("sb_unexpected_write", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check_value("core_addr", 32'(core_bus.core_addr), 32'(e.addr));
            check_value("core_wdata", 32'(core_bus.core_wdata), 32'(e.data));
          end
          if (check_spacing && ack_count > 0)
            check_value("ack_spacing", 32'(cyc - last_ack_cyc), 32'd4);
          ack_count++;
          last_ack_cyc = cyc;
        end
      end
      prev_wr   = core_bus.core_wr;
      prev_ack  = core_bus.core_ack;
      prev_addr = core_bus.core_addr;
      prev_data = core_bus.core_wdata;
    end
  end

  // Hard stop if the stimulus sequence ever stalls.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [DATA_W-1:0] rd;
    int done_cyc;
    int pulses;
    int n;

    reset = 1'b1; clear = 1'b0; host_wr = 1'b0; host_addr = '0;
    host_wdata = '0; host_rd_addr = '0; save_req = 1'b0;
    core_valid_drv = 1'b0; ack_hold_word = -1;
    repeat (3) tick();

    check_value("rst_core_wr", 32'(core_bus.core_wr), 32'd0);
    check_value("rst_core_addr", 32'(core_bus.core_addr), 32'd0);
    check_value("rst_core_wdata", 32'(core_bus.core_wdata), 32'd0);
    check_value("rst_load_done", 32'(load_done), 32'd0);
    check_value("rst_save_done", 32'(save_done), 32'd0);
    check_value("rst_busy", 32'(busy), 32'd0);
    check_value("rst_host_rdata", 32'(host_rdata), 32'd0);
    reset = 1'b0;
    tick();

    // Nothing loaded: core_valid alone must not start a transfer.
    wr_cycles = 0;
    core_valid_drv = 1'b1;
    repeat (100) tick();
    check_value("idle_no_core_wr", 32'(wr_cycles), 32'd0);
    check_value("idle_busy", 32'(busy), 32'd0);
    core_valid_drv = 1'b0;

    // Basic load with ack tied high.
    for (int i = 0; i < DEPTH; i++) begin
      exp_mem[i] = 16'(32'h1000 + i);
      host_write(i, exp_mem[i]);
    end
    host_read(3, rd);
    check_value("host_readback_3", 32'(rd), 32'h1003);
    push_all();
    check_spacing = 1'b1; ack_count = 0; wr_cycles = 0;
    core_valid_drv = 1'b1;
    wait_load_done(300, done_cyc);
    // Last word: ack in LD_WR, then LD_INC, then DONE with load_done set.
    check_value("load_done_latency", 32'(done_cyc - last_ack_cyc), 32'd2);
    check_value("load_ack_count", 32'(ack_count), 32'd10);
    check_value("load_wr_cycles", 32'(wr_cycles), 32'd10);
    check_value("load_sb_empty", 32'(sb_q.size()), 32'd0);
    check_value("load_busy_after", 32'(busy), 32'd0);
    check_spacing = 1'b0;

    // Save from DONE.
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      if (save_done) pulses++;
      tick();
    end
    check_value("save_done_pulses", 32'(pulses), 32'd1);
    check_value("save_load_done_kept", 32'(load_done), 32'd1);
    check_value("save_busy_after", 32'(busy), 32'd0);
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 16'(32'hA000 | i);
    host_read(7, rd);
    check_value("save_readback_7", 32'(rd), 32'hA007);
    for (int i = 0; i < DEPTH; i++) begin
      host_read(i, rd);
      check_value("save_readback", 32'(rd), 32'(exp_mem[i]));
    end

    // Load with delayed ack on word 4.
    core_valid_drv = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_value("clear_load_done", 32'(load_done), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      exp_mem[i] = 16'(32'h2000 + i);
      host_write(i, exp_mem[i]);
    end
    push_all();
    ack_hold_word = 4; wr_cycles = 0; word_wr_cycles = 0; ack_count = 0;
    core_valid_drv = 1'b1;
    wait_load_done(300, done_cyc);
    check_value("hold_word_cycles", 32'(word_wr_cycles), 32'd4);
    check_value("hold_total_wr", 32'(wr_cycles), 32'd13);
    check_value("hold_ack_count", 32'(ack_count), 32'd10);
    check_value("hold_sb_empty", 32'(sb_q.size()), 32'd0);

    // Clear during LD_WR of word 3.
    core_valid_drv = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_mem[i] = 16'(32'h3000 + i);
      host_write(i, exp_mem[i]);
    end
    push_all();
    ack_hold_word = 3; ack_count = 0;
    core_valid_drv = 1'b1;
    n = 0;
    while (n < 200) begin
      @(negedge clk_sys);
      if (core_bus.core_wr && core_bus.core_addr == CORE_AW'(3)) break;
      n++;
    end
    check_value("reach_ld_wr_word3", 32'(n < 200), 32'd1);
    clear = 1'b1;
    @(posedge clk_sys);
    #1;
    clear = 1'b0;
    check_value("clear_core_wr", 32'(core_bus.core_wr), 32'd0);
    check_value("clear_busy", 32'(busy), 32'd0);
    check_value("clear_load_done2", 32'(load_done), 32'd0);
    check_value("clear_acks_before", 32'(ack_count), 32'd3);
    sb_q.delete();
    repeat (5) tick();
    check_value("clear_no_restart", 32'(busy), 32'd0);

    // Out-of-range host write: buffer untouched, flag still armed.
    ack_hold_word = -1; ack_count = 0; wr_cycles = 0;
    push_all();
    host_write(12, 16'hDEAD);
    wait_load_done(300, done_cyc);
    check_value("restart_ack_count", 32'(ack_count), 32'd10);
    check_value("restart_sb_empty", 32'(sb_q.size()), 32'd0);
    check_value("restart_busy_after", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
